// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with stall/flush, branch resolution from ALU flags and
// saturating branch/redirect performance counters.
module ex_mem_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ValidE,
   input  logic [XLEN-1:0]  ALUResE,
   input  logic             ZeroE,
   input  logic [XLEN-1:0]  WriteDataE,
   input  logic [XLEN-1:0]  PCPlus4E,
   input  logic [XLEN-1:0]  PCTargetE,
   input  logic [4:0]       RdE,
   input  logic             RegWriteE,
   input  logic             MemWriteE,
   input  logic [1:0]       ResultSrcE,
   input  logic             BranchE,
   input  logic             JumpE,
   input  logic [2:0]       Funct3E,
   input  logic             StallM,
   input  logic             FlushM,
   output logic             PCSrcE,
   output logic [XLEN-1:0]  PCTargetOut,
   output logic             ValidM,
   output logic             RegWriteM,
   output logic             MemWriteM,
   output logic [1:0]       ResultSrcM,
   output logic [4:0]       RdM,
   output logic [XLEN-1:0]  ALUResM,
   output logic [XLEN-1:0]  WriteDataM,
   output logic [XLEN-1:0]  PCPlus4M,
   output logic [CNT_W-1:0] BrCnt,
   output logic [CNT_W-1:0] TakenCnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             w_cond;
   logic             w_adv;
   logic             w_redirect;
   logic             r_valid_m;
   logic             r_regwrite_m;
   logic             r_memwrite_m;
   logic [1:0]       r_resultsrc_m;
   logic [4:0]       r_rd_m;
   logic [XLEN-1:0]  r_alures_m;
   logic [XLEN-1:0]  r_writedata_m;
   logic [XLEN-1:0]  r_pcplus4_m;
   logic [CNT_W-1:0] r_br_cnt;
   logic [CNT_W-1:0] r_taken_cnt;

   // Equality branches use sub (zero flag); ordered branches use slt/sltu (bit 0).
   always_comb begin
      w_cond = 1'b0;
      case (Funct3E)
         3'b000:         w_cond = ZeroE;
         3'b001:         w_cond = ~ZeroE;
         3'b100, 3'b110: w_cond = ALUResE[0];
         3'b101, 3'b111: w_cond = ~ALUResE[0];
         default:        w_cond = 1'b0;
      endcase
   end

   assign w_adv      = ValidE & ~StallM & ~FlushM;
   assign w_redirect = w_adv & (JumpE | (BranchE & w_cond));

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_valid_m     <= 1'b0;
         r_regwrite_m  <= 1'b0;
         r_memwrite_m  <= 1'b0;
         r_resultsrc_m <= '0;
         r_rd_m        <= '0;
         r_alures_m    <= '0;
         r_writedata_m <= '0;
         r_pcplus4_m   <= '0;
      end else if (FlushM) begin
         r_valid_m     <= 1'b0;
         r_regwrite_m  <= 1'b0;
         r_memwrite_m  <= 1'b0;
         r_resultsrc_m <= '0;
         r_rd_m        <= '0;
         r_alures_m    <= '0;
         r_writedata_m <= '0;
         r_pcplus4_m   <= '0;
      end else if (!StallM) begin
         r_valid_m     <= ValidE;
         r_regwrite_m  <= RegWriteE & ValidE;
         r_memwrite_m  <= MemWriteE & ValidE;
         r_resultsrc_m <= ResultSrcE;
         r_rd_m        <= RdE;
         r_alures_m    <= ALUResE;
         r_writedata_m <= WriteDataE;
         r_pcplus4_m   <= PCPlus4E;
      end
   end

   // w_adv already excludes stall and flush, so counters hold in those cycles.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_br_cnt    <= '0;
         r_taken_cnt <= '0;
      end else begin
         if (w_adv && BranchE && (r_br_cnt != CNT_MAX))
            r_br_cnt <= r_br_cnt + 1'b1;
         if (w_redirect && (r_taken_cnt != CNT_MAX))
            r_taken_cnt <= r_taken_cnt + 1'b1;
      end
   end

   assign PCSrcE      = w_redirect;
   assign PCTargetOut = PCTargetE;
   assign ValidM      = r_valid_m;
   assign RegWriteM   = r_regwrite_m;
   assign MemWriteM   = r_memwrite_m;
   assign ResultSrcM  = r_resultsrc_m;
   assign RdM         = r_rd_m;
   assign ALUResM     = r_alures_m;
   assign WriteDataM  = r_writedata_m;
   assign PCPlus4M    = r_pcplus4_m;
   assign BrCnt       = r_br_cnt;
   assign TakenCnt    = r_taken_cnt;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: branch-condition table, directed corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid, zero, rw, mw, br, jp, stall, flush;
   logic [31:0] alu, wd, pc4, tgt;
   logic [4:0]  rd;
   logic [1:0]  rs;
   logic [2:0]  f3;

   logic        pcsrc, validm, rwm, mwm;
   logic [31:0] tgto, alum, wdm, pc4m;
   logic [1:0]  rsm;
   logic [4:0]  rdm;
   logic [15:0] brc, tkc;

   logic        pcsrc4, validm4, rwm4, mwm4;
   logic [31:0] tgto4, alum4, wdm4, pc4m4;
   logic [1:0]  rsm4;
   logic [4:0]  rdm4;
   logic [3:0]  brc4, tkc4;

   int checks = 0;
   int failures = 0;

   // reference model state
   logic        m_valid, m_rw, m_mw;
   logic [1:0]  m_rs;
   logic [4:0]  m_rd;
   logic [31:0] m_alu, m_wd, m_pc4;
   int          m_br16, m_tk16, m_br4, m_tk4;

   always #5 clk = ~clk;

   ex_mem_stage #(.XLEN(32), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .ValidE(valid), .ALUResE(alu), .ZeroE(zero),
      .WriteDataE(wd), .PCPlus4E(pc4), .PCTargetE(tgt), .RdE(rd), .RegWriteE(rw),
      .MemWriteE(mw), .ResultSrcE(rs), .BranchE(br), .JumpE(jp), .Funct3E(f3),
      .StallM(stall), .FlushM(flush), .PCSrcE(pcsrc), .PCTargetOut(tgto),
      .ValidM(validm), .RegWriteM(rwm), .MemWriteM(mwm), .ResultSrcM(rsm), .RdM(rdm),
      .ALUResM(alum), .WriteDataM(wdm), .PCPlus4M(pc4m), .BrCnt(brc), .TakenCnt(tkc));

   ex_mem_stage #(.XLEN(32), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .ValidE(valid), .ALUResE(alu), .ZeroE(zero),
      .WriteDataE(wd), .PCPlus4E(pc4), .PCTargetE(tgt), .RdE(rd), .RegWriteE(rw),
      .MemWriteE(mw), .ResultSrcE(rs), .BranchE(br), .JumpE(jp), .Funct3E(f3),
      .StallM(stall), .FlushM(flush), .PCSrcE(pcsrc4), .PCTargetOut(tgto4),
      .ValidM(validm4), .RegWriteM(rwm4), .MemWriteM(mwm4), .ResultSrcM(rsm4), .RdM(rdm4),
      .ALUResM(alum4), .WriteDataM(wdm4), .PCPlus4M(pc4m4), .BrCnt(brc4), .TakenCnt(tkc4));

   typedef struct {
      logic       valid, stall, flush, br, jp;
      logic [2:0] f3;
      logic       zero, res0;
      logic       exp;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Branch semantics: beq/bne on equality, blt/bltu taken when "less" bit set,
   // bge/bgeu taken when it is clear; 010/011 are not branches.
   function automatic logic branch_taken(input logic [2:0] f, input logic z, input logic lt);
      case (f)
         3'd0:       return z;
         3'd1:       return !z;
         3'd4, 3'd6: return lt;
         3'd5, 3'd7: return !lt;
         default:    return 1'b0;
      endcase
   endfunction

   function automatic logic exp_redirect();
      logic moving;
      moving = valid && !stall && !flush;
      return moving && (jp || (br && branch_taken(f3, zero, alu[0])));
   endfunction

   task automatic model_edge();
      logic moving, redir;
      moving = valid && !stall && !flush;
      redir  = exp_redirect();
      if (!rst) begin
         {m_valid, m_rw, m_mw} = 3'b000;
         m_rs = 0; m_rd = 0; m_alu = 0; m_wd = 0; m_pc4 = 0;
         m_br16 = 0; m_tk16 = 0; m_br4 = 0; m_tk4 = 0;
      end else begin
         if (flush) begin
            {m_valid, m_rw, m_mw} = 3'b000;
            m_rs = 0; m_rd = 0; m_alu = 0; m_wd = 0; m_pc4 = 0;
         end else if (!stall) begin
            m_valid = valid; m_rw = rw && valid; m_mw = mw && valid;
            m_rs = rs; m_rd = rd; m_alu = alu; m_wd = wd; m_pc4 = pc4;
         end
         if (moving && br) begin
            m_br16 = (m_br16 < 65535) ? m_br16 + 1 : m_br16;
            m_br4  = (m_br4 < 15) ? m_br4 + 1 : m_br4;
         end
         if (redir) begin
            m_tk16 = (m_tk16 < 65535) ? m_tk16 + 1 : m_tk16;
            m_tk4  = (m_tk4 < 15) ? m_tk4 + 1 : m_tk4;
         end
      end
   endtask

   task automatic check_regs();
      chk("ValidM", {31'b0, validm}, {31'b0, m_valid});
      chk("RegWriteM", {31'b0, rwm}, {31'b0, m_rw});
      chk("MemWriteM", {31'b0, mwm}, {31'b0, m_mw});
      chk("ResultSrcM", {30'b0, rsm}, {30'b0, m_rs});
      chk("RdM", {27'b0, rdm}, {27'b0, m_rd});
      chk("ALUResM", alum, m_alu);
      chk("WriteDataM", wdm, m_wd);
      chk("PCPlus4M", pc4m, m_pc4);
      chk("BrCnt", {16'b0, brc}, m_br16);
      chk("TakenCnt", {16'b0, tkc}, m_tk16);
      chk("BrCnt4", {28'b0, brc4}, m_br4);
      chk("TakenCnt4", {28'b0, tkc4}, m_tk4);
      chk("ValidM4", {31'b0, validm4}, {31'b0, m_valid});
      chk("ALUResM4", alum4, m_alu);
   endtask

   // Called ~1ns after a rising edge with inputs already applied.
   task automatic step();
      #1;
      chk("PCSrcE", {31'b0, pcsrc}, {31'b0, exp_redirect()});
      chk("PCSrcE4", {31'b0, pcsrc4}, {31'b0, exp_redirect()});
      chk("PCTargetOut", tgto, tgt);
      @(posedge clk);
      model_edge();
      #1;
      check_regs();
   endtask

   task automatic idle();
      rst = 1; valid = 0; zero = 0; rw = 0; mw = 0; br = 0; jp = 0; stall = 0; flush = 0;
      alu = 0; wd = 0; pc4 = 0; tgt = 0; rd = 0; rs = 0; f3 = 0;
   endtask

   task automatic do_reset();
      idle(); rst = 0; step(); rst = 1;
   endtask

   int sv_tk, sv_br;

   initial begin
      vecs[0]  = '{1,0,0,1,0,3'd0,1,0,1};
      vecs[1]  = '{1,0,0,1,0,3'd0,0,0,0};
      vecs[2]  = '{1,0,0,1,0,3'd1,0,0,1};
      vecs[3]  = '{1,0,0,1,0,3'd1,1,0,0};
      vecs[4]  = '{1,0,0,1,0,3'd4,0,1,1};
      vecs[5]  = '{1,0,0,1,0,3'd4,0,0,0};
      vecs[6]  = '{1,0,0,1,0,3'd5,0,0,1};
      vecs[7]  = '{1,0,0,1,0,3'd6,0,1,1};
      vecs[8]  = '{1,0,0,1,0,3'd7,0,1,0};
      vecs[9]  = '{1,0,0,1,0,3'd7,0,0,1};
      vecs[10] = '{1,0,0,1,0,3'd2,1,1,0};
      vecs[11] = '{1,0,0,1,0,3'd3,1,1,0};
      vecs[12] = '{1,0,0,0,1,3'd2,0,0,1};
      vecs[13] = '{0,0,0,1,1,3'd0,1,1,0};
      vecs[14] = '{1,1,0,1,1,3'd0,1,1,0};
      vecs[15] = '{1,0,1,1,1,3'd0,1,1,0};
      vecs[16] = '{1,0,0,0,0,3'd0,1,1,0};

      idle();
      m_br16 = 0; m_tk16 = 0; m_br4 = 0; m_tk4 = 0;
      @(posedge clk); #1;
      do_reset();
      chk("reset_ValidM", {31'b0, validm}, 32'd0);
      chk("reset_BrCnt", {16'b0, brc}, 32'd0);

      // beq taken then not taken
      idle(); valid = 1; br = 1; f3 = 3'd0; zero = 1; tgt = 32'h100;
      #1; chk("beq_taken_PCSrcE", {31'b0, pcsrc}, 32'd1);
      step();
      chk("beq_BrCnt", {16'b0, brc}, 32'd1);
      chk("beq_TakenCnt", {16'b0, tkc}, 32'd1);
      zero = 0;
      #1; chk("beq_nt_PCSrcE", {31'b0, pcsrc}, 32'd0);
      step();
      chk("beq_nt_BrCnt", {16'b0, brc}, 32'd2);
      chk("beq_nt_TakenCnt", {16'b0, tkc}, 32'd1);

      // condition table
      for (int i = 0; i < 17; i++) begin
         idle();
         valid = vecs[i].valid; stall = vecs[i].stall; flush = vecs[i].flush;
         br = vecs[i].br; jp = vecs[i].jp; f3 = vecs[i].f3; zero = vecs[i].zero;
         alu = {$urandom_range(0, 32'h7FFF_FFFF), vecs[i].res0};
         tgt = $urandom; pc4 = $urandom;
         #1; chk($sformatf("vec%0d_PCSrcE", i), {31'b0, pcsrc}, {31'b0, vecs[i].exp});
         step();
      end

      // pipeline load, then invalid slot with same data
      idle(); valid = 1; alu = 32'hDEADBEEF; rd = 5'd5; rw = 1; step();
      chk("pipe_ALUResM", alum, 32'hDEADBEEF);
      chk("pipe_RdM", {27'b0, rdm}, 32'd5);
      chk("pipe_RegWriteM", {31'b0, rwm}, 32'd1);
      chk("pipe_ValidM", {31'b0, validm}, 32'd1);
      valid = 0; step();
      chk("pipe_inv_RegWriteM", {31'b0, rwm}, 32'd0);
      chk("pipe_inv_ValidM", {31'b0, validm}, 32'd0);

      // jal stalled 3 cycles then released: exactly one redirect
      idle(); valid = 1; alu = 32'h1234; rd = 5'd1; rw = 1; step();
      sv_tk = tkc;
      jp = 1; tgt = 32'h200; alu = 32'h5555; rd = 5'd2; stall = 1;
      for (int c = 0; c < 3; c++) begin
         #1; chk("stall_PCSrcE", {31'b0, pcsrc}, 32'd0);
         step();
         chk("stall_hold_ALUResM", alum, 32'h1234);
      end
      stall = 0;
      #1; chk("release_PCSrcE", {31'b0, pcsrc}, 32'd1);
      step();
      chk("release_TakenCnt", {16'b0, tkc}, sv_tk + 1);
      jp = 0; valid = 0; step();

      // flush beats stall
      sv_tk = tkc; sv_br = brc;
      idle(); valid = 1; mw = 1; br = 1; jp = 1; stall = 1; flush = 1;
      #1; chk("flushstall_PCSrcE", {31'b0, pcsrc}, 32'd0);
      step();
      chk("flush_MemWriteM", {31'b0, mwm}, 32'd0);
      chk("flush_ValidM", {31'b0, validm}, 32'd0);
      chk("flush_TakenCnt", {16'b0, tkc}, sv_tk);
      chk("flush_BrCnt", {16'b0, brc}, sv_br);

      // reset during a stalled jump
      idle(); valid = 1; jp = 1; rw = 1; rd = 5'd9; step();
      stall = 1; step();
      rst = 0; step();
      chk("rststall_ValidM", {31'b0, validm}, 32'd0);
      chk("rststall_TakenCnt", {16'b0, tkc}, 32'd0);

      // saturation on the 4-bit counter instance
      idle(); valid = 1; jp = 1;
      for (int k = 0; k < 20; k++) step();
      chk("sat_TakenCnt4", {28'b0, tkc4}, 32'd15);
      chk("sat_TakenCnt16", {16'b0, tkc}, 32'd20);
      idle(); rst = 0; valid = 1; jp = 1; alu = 32'hFFFF_FFFF; step();
      chk("sat_reset_TakenCnt4", {28'b0, tkc4}, 32'd0);
      chk("sat_reset_ALUResM", alum, 32'd0);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         rst   = ($urandom_range(0, 60) != 0);
         valid = ($urandom_range(0, 3) != 0);
         alu   = $urandom; zero = 1'($urandom); wd = $urandom;
         pc4   = $urandom; tgt = $urandom; rd = 5'($urandom);
         rw    = 1'($urandom); mw = 1'($urandom); rs = 2'($urandom);
         br    = ($urandom_range(0, 2) == 0);
         jp    = !br && ($urandom_range(0, 3) == 0);
         f3    = 3'($urandom);
         stall = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 6) == 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
